tx_frame_packer: RTL and testbench

Serialises a block of 16-bit result words into a framed byte stream for the transmit FIFO, the outbound counterpart of the byte-pair instruction/word assembly done on the receive side. Emits a sync byte, a header carrying the opcode, a word count, the payload (low byte first), and an optional XOR checksum. Sits between the unified buffer's word read port and the tx FIFO write port, driven by the top-level controller.

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/tx_frame_packer.sv | 143 ++++++++++++++
 tb/tb_tx_frame_packer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU package: opcode enum, transmit sync byte and the frame packer
// state encoding. Imported by tx_frame_packer.
package tpu_pkg;

  typedef enum logic [2:0] {
    STORE_OP = 3'd0,
    FETCH_OP = 3'd1,
    RUN_OP   = 3'd2,
    LOAD_OP  = 3'd3,
    HALT_OP  = 3'd4,
    NOP      = 3'd5
  } opcode_e;

  localparam logic [7:0] TX_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    HEADER = 3'd2,
    LEN    = 3'd3,
    LO     = 3'd4,
    HI     = 3'd5,
    CSUM   = 3'd6,
    DONE   = 3'd7
  } tx_frame_state_e;

endpackage

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: serialises a block of 16-bit buffer words into a framed
// byte stream for the tx FIFO:
//   0xA5, {5'b0,opcode}, count, lo0, hi0, lo1, hi1, ... [, xor checksum]
// The checksum covers HEADER, LEN and payload bytes (not SYNC). It is only
// built when TX_CHECKSUM_EN is defined; otherwise the frame ends after the
// last payload byte (or after LEN for an empty frame).
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle frame request, honoured only in IDLE
//   opcode          header opcode, latched with start
//   word_count      payload words, latched with start, saturated to MAX_WORDS
//   busy, done      not-IDLE flag, one-cycle completion pulse
//   word_valid/data buffer word port; word_ready = consumed this cycle
//   fifo_full       tx FIFO full flag
//   fifo_we/w_data  tx FIFO write port (data forced to 0 when not writing)
module tx_frame_packer
  import tpu_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int OPCODE_WIDTH     = 3,
  parameter int MAX_WORDS        = 64,
  parameter int LEN_WIDTH        = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [OPCODE_WIDTH-1:0]     opcode,
  input  logic [LEN_WIDTH-1:0]        word_count,
  output logic                        busy,
  output logic                        done,
  input  logic                        word_valid,
  input  logic [BUFFER_WORD_SIZE-1:0] word_data,
  output logic                        word_ready,
  input  logic                        fifo_full,
  output logic                        fifo_we,
  output logic [FIFO_DATA_WIDTH-1:0]  fifo_w_data
);

  // State after the last payload byte (or after LEN of an empty frame).
`ifdef TX_CHECKSUM_EN
  localparam tx_frame_state_e TAIL = CSUM;
`else
  localparam tx_frame_state_e TAIL = DONE;
`endif

  tx_frame_state_e             state, state_nx;
  logic [OPCODE_WIDTH-1:0]     op_q;
  logic [LEN_WIDTH-1:0]        len_q, rem_q, len_sat;
  logic [FIFO_DATA_WIDTH-1:0]  hi_q, byte_c;
  logic                        wr;
`ifdef TX_CHECKSUM_EN
  logic [FIFO_DATA_WIDTH-1:0]  csum_q;
`endif

  assign len_sat = (word_count > LEN_WIDTH'(MAX_WORDS)) ? LEN_WIDTH'(MAX_WORDS) : word_count;

  always_comb begin
    state_nx   = state;
    byte_c     = '0;
    wr         = 1'b0;
    word_ready = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = SYNC;
      SYNC: begin
        wr     = ~fifo_full;
        byte_c = TX_SYNC_BYTE;
        if (wr) state_nx = HEADER;
      end
      HEADER: begin
        wr     = ~fifo_full;
        byte_c = FIFO_DATA_WIDTH'(op_q);
        if (wr) state_nx = LEN;
      end
      LEN: begin
        wr     = ~fifo_full;
        byte_c = FIFO_DATA_WIDTH'(len_q);
        if (wr) state_nx = (len_q == '0) ? TAIL : LO;
      end
      LO: begin
        // A word is only taken when its low byte can be written the same cycle.
        word_ready = ~fifo_full;
        wr         = word_valid & ~fifo_full;
        byte_c     = word_data[FIFO_DATA_WIDTH-1:0];
        if (wr) state_nx = HI;
      end
      HI: begin
        wr     = ~fifo_full;
        byte_c = hi_q;
        if (wr) state_nx = (rem_q == '0) ? TAIL : LO;
      end
`ifdef TX_CHECKSUM_EN
      CSUM: begin
        wr     = ~fifo_full;
        byte_c = csum_q;
        if (wr) state_nx = DONE;
      end
`endif
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign fifo_we     = wr;
  assign fifo_w_data = wr ? byte_c : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= '0;
      len_q <= '0;
      rem_q <= '0;
      hi_q  <= '0;
`ifdef TX_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_q  <= opcode;
        len_q <= len_sat;
        rem_q <= len_sat;
`ifdef TX_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      if (state == LO && wr) begin
        hi_q  <= word_data[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
        rem_q <= rem_q - 1'b1;
      end
`ifdef TX_CHECKSUM_EN
      if (wr && state != SYNC) csum_q <= csum_q ^ byte_c;
`endif
    end
  end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Scoreboard bench for tx_frame_packer. The stimulus task builds each frame's
// expected byte list from the framing rules and queues it; a monitor pops and
// compares on every fifo_we and checks done/backpressure behaviour.
module tb_tx_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = '0;
  logic [6:0]  word_count = '0;
  logic        busy, done;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = '0;
  logic        word_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_we;
  logic [7:0]  fifo_w_data;

  tx_frame_packer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .word_count(word_count),
    .busy(busy), .done(done), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .fifo_full(fifo_full), .fifo_we(fifo_we),
    .fifo_w_data(fifo_w_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wq[$];
  int frame_bytes = 0;
  int done_cnt = 0;
  bit prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_we) begin
        if (exp_q.size() == 0) chk("extra_byte", {24'b0, fifo_w_data}, 32'hFFFF_FFFF);
        else chk("byte", {24'b0, fifo_w_data}, {24'b0, exp_q.pop_front()});
        frame_bytes++;
      end
      if (fifo_full) begin
        chk("we_on_full", {31'b0, fifo_we}, 0);
        chk("ready_on_full", {31'b0, word_ready}, 0);
      end
      if (word_ready) chk("ready_no_word", {31'b0, wq.size() != 0}, 1);
      if (done) begin
        chk("done_after_last", {31'b0, prev_we}, 1);
        chk("done_all_bytes", exp_q.size(), 0);
        chk("done_busy", {31'b0, busy}, 1);
        done_cnt++;
      end
      prev_we = fifo_we;
    end
  end

  task automatic run_frame(input int op, input int cnt, input int full_pct, input int valid_pct,
                           input int stall_byte, input int stall_len, input int stall_kind,
                           input int abort_byte, input bit stray);
    int sat, nexp, d0, cyc, stall_left;
    logic [7:0] cs;
    bit took;
    sat = (cnt > 64) ? 64 : cnt;
    if (wq.size() == 0) for (int i = 0; i < sat; i++) wq.push_back(16'($urandom));
    cs = 8'(op) ^ 8'(sat);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(op));
    exp_q.push_back(8'(sat));
    for (int i = 0; i < sat; i++) begin
      exp_q.push_back(wq[i][7:0]);
      exp_q.push_back(wq[i][15:8]);
      cs = cs ^ wq[i][7:0] ^ wq[i][15:8];
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    nexp = exp_q.size();
    frame_bytes = 0;
    d0 = done_cnt;
    stall_left = stall_len;
    start = 1'b1; opcode = 3'(op); word_count = 7'(cnt);
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom); word_count = 7'($urandom);
    chk("busy_after_start", {31'b0, busy}, 1);
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      if (abort_byte >= 0 && frame_bytes == abort_byte) begin
        rst = 1'b0; #1;
        chk("rst_outputs", {27'b0, fifo_we, word_ready, busy, done, |fifo_w_data}, 0);
        exp_q.delete(); wq.delete();
        word_valid = 1'b0; fifo_full = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      fifo_full  = ($urandom_range(99) < full_pct);
      word_valid = (wq.size() > 0) && ($urandom_range(99) < valid_pct);
      word_data  = (wq.size() > 0) ? wq[0] : 16'($urandom);
      if (frame_bytes == stall_byte && stall_left > 0) begin
        if (stall_kind == 0) fifo_full = 1'b1; else word_valid = 1'b0;
        stall_left--;
      end
      start = stray && busy && ($urandom_range(3) == 0);
      @(negedge clk);
      took = word_valid && word_ready;
      @(posedge clk); #1;
      if (took) void'(wq.pop_front());
      cyc++;
    end
    start = 1'b0; word_valid = 1'b0; fifo_full = 1'b0;
    if (done_cnt == d0) begin
      chk("timeout", 0, 1);
      rst = 1'b0; exp_q.delete(); wq.delete();
      @(posedge clk); #1; rst = 1'b1;
      return;
    end
    chk("idle_after_done", {31'b0, busy}, 0);
    if (full_pct == 0 && valid_pct == 100 && stall_len == 0) chk("latency", cyc, nexp + 1);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {27'b0, fifo_we, word_ready, busy, done, |fifo_w_data}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    wq = '{16'h1234, 16'hBEEF};
    run_frame(1, 2, 0, 100, -1, 0, 0, -1, 0);   // basic 2-word frame
    run_frame(4, 0, 0, 100, -1, 0, 0, -1, 0);   // zero-length frame
    wq = '{16'h1234, 16'hBEEF};
    run_frame(1, 2, 0, 100, 4, 3, 0, -1, 0);    // fifo_full in HI of word 0
    wq = '{16'h1234, 16'hBEEF};
    run_frame(1, 2, 0, 100, 3, 5, 1, -1, 0);    // word starvation in LO
    run_frame(2, 100, 0, 100, -1, 0, 0, -1, 1); // saturation + stray starts
    run_frame(3, 5, 0, 100, -1, 0, 0, 2, 0);    // reset after HEADER
    wq = '{16'h1234, 16'hBEEF};
    run_frame(1, 2, 0, 100, -1, 0, 0, -1, 0);   // fresh frame after reset
    run_frame(7, 64, 0, 100, -1, 0, 0, -1, 0);  // exactly MAX_WORDS
    for (int n = 0; n < 20; n++)
      run_frame(int'($urandom_range(7)), int'($urandom_range(70)), int'($urandom_range(40)),
                int'($urandom_range(100, 50)), -1, 0, 0, -1, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
